// File: rtl/uart_rx_deframer_if.sv
// Byte stream from the UART receive deframer to its consumer.
// Valid/ready handshake; a transfer occurs when both are high.
interface uart_rx_deframer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// 8N1 serial receive deframer with mid-bit sampling.
// Received bytes are buffered in a fall-through FIFO.
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    uart_rx_deframer_if.master byte_if,
    output logic               frame_err,
    output logic               overrun,
    output logic               busy
);

    localparam int BW    = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [BW-1:0]    HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0]    FULL_M1 = BW'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Synchronizer and falling-edge detect
    logic rx_s1;
    logic rx_s;
    logic live1;
    logic live;
    logic prev_hi;
    logic fall;

    // prev_hi only counts highs that came from the pin, not reset values,
    // so a frame in flight at reset release cannot fake a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s    <= 1'b1;
            live1   <= 1'b0;
            live    <= 1'b0;
            prev_hi <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s    <= rx_s1;
            live1   <= 1'b1;
            live    <= live1;
            prev_hi <= live & rx_s;
        end
    end

    assign fall = prev_hi & ~rx_s;

    // Frame FSM
    state_t          state_q;
    state_t          state_d;
    logic [BW-1:0]   cnt_q;
    logic [BW-1:0]   cnt_d;
    logic [2:0]      bit_q;
    logic [2:0]      bit_d;
    logic [7:0]      sh_q;
    logic [7:0]      sh_d;
    logic            push_req;
    logic            ferr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + BW'(1);
        bit_d    = bit_q;
        sh_d     = sh_q;
        push_req = 1'b0;
        ferr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        bit_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        push_req = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

    // Byte FIFO
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             pop;
    logic             push;
    logic             full_ap;

    assign pop     = (count != '0) & byte_if.rx_ready;
    // Fullness is judged after a same-cycle pop frees a slot.
    assign full_ap = (count - CNT_W'(pop)) == DEPTH_C;
    assign push    = push_req & ~full_ap;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sh_q;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count + CNT_W'(push) - CNT_W'(pop);
            frame_err <= ferr_d;
            overrun   <= push_req & full_ap;
        end
    end

    assign byte_if.rx_data  = mem[rd_ptr];
    assign byte_if.rx_valid = (count != '0);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at 8 clocks per bit.
// Inputs change 1 time unit after posedge; outputs are checked at negedge.
module tb_uart_rx_deframer;

    logic clk = 1'b0;
    logic reset;
    logic rx;
    logic frame_err;
    logic overrun;
    logic busy;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    uart_rx_deframer_if bif ();

    uart_rx_deframer #(
        .CLKS_PER_BIT(8),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .byte_if  (bif.master),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start bit plus eight data bits; leaves the caller at the stop bit.
    task automatic send_head(input logic [7:0] d);
        rx = 1'b0;
        tick(8);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(8);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_head(d);
        rx = stop;
        tick(8);
        rx = 1'b1;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(bif.rx_valid), 32'd1);
        chk({tag, "_data"}, 32'(bif.rx_data), 32'(exp));
        bif.rx_ready = 1'b1;
        tick(1);
        bif.rx_ready = 1'b0;
    endtask

    int fe0;
    int ov0;

    initial begin
        reset        = 1'b1;
        rx           = 1'b1;
        bif.rx_ready = 1'b0;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(bif.rx_valid), 32'd0);
        chk("rst_data", 32'(bif.rx_data), 32'h00);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick(10);

        // Single byte, exact stop-sample timing
        send_head(8'hA5);
        rx = 1'b1;
        tick(6);
        @(negedge clk);
        chk("t1_pre_valid", 32'(bif.rx_valid), 32'd0);
        chk("t1_pre_busy", 32'(busy), 32'd1);
        tick(1);
        @(negedge clk);
        chk("t1_valid", 32'(bif.rx_valid), 32'd1);
        chk("t1_data", 32'(bif.rx_data), 32'hA5);
        chk("t1_busy", 32'(busy), 32'd0);
        tick(1);
        bif.rx_ready = 1'b1;
        tick(1);
        bif.rx_ready = 1'b0;
        @(negedge clk);
        chk("t1_drained", 32'(bif.rx_valid), 32'd0);
        tick(10);

        // Glitch rejection
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rx  = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(3);
        @(negedge clk);
        chk("t2_busy_start", 32'(busy), 32'd1);
        tick(20);
        @(negedge clk);
        chk("t2_busy_idle", 32'(busy), 32'd0);
        chk("t2_valid", 32'(bif.rx_valid), 32'd0);
        chk("t2_pulses", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);

        // Framing error then a good byte
        fe0 = fe_cnt;
        send_head(8'h3C);
        rx = 1'b0;
        tick(6);
        @(negedge clk);
        chk("t3_ferr_pre", 32'(frame_err), 32'd0);
        tick(1);
        @(negedge clk);
        chk("t3_ferr", 32'(frame_err), 32'd1);
        chk("t3_valid", 32'(bif.rx_valid), 32'd0);
        tick(1);
        @(negedge clk);
        chk("t3_ferr_post", 32'(frame_err), 32'd0);
        rx = 1'b1;
        tick(8);
        send_frame(8'h11, 1'b1);
        tick(1);
        chk("t3_ferr_count", 32'(fe_cnt - fe0), 32'd1);
        pop_chk("t3_next", 8'h11);
        @(negedge clk);
        chk("t3_empty", 32'(bif.rx_valid), 32'd0);
        tick(10);

        // Overrun on the fifth back-to-back byte
        ov0 = ov_cnt;
        for (int b = 1; b <= 4; b++) begin
            send_frame(8'(b), 1'b1);
        end
        chk("t4_no_ovr_yet", 32'(ov_cnt - ov0), 32'd0);
        send_frame(8'h05, 1'b1);
        tick(2);
        chk("t4_ovr_count", 32'(ov_cnt - ov0), 32'd1);
        pop_chk("t4_b1", 8'h01);
        pop_chk("t4_b2", 8'h02);
        pop_chk("t4_b3", 8'h03);
        pop_chk("t4_b4", 8'h04);
        @(negedge clk);
        chk("t4_empty", 32'(bif.rx_valid), 32'd0);
        tick(10);

        // Full FIFO with a pop in the push cycle
        ov0 = ov_cnt;
        send_frame(8'h10, 1'b1);
        send_frame(8'h20, 1'b1);
        send_frame(8'h30, 1'b1);
        send_frame(8'h40, 1'b1);
        send_head(8'h55);
        rx = 1'b1;
        tick(6);
        bif.rx_ready = 1'b1;
        tick(1);
        bif.rx_ready = 1'b0;
        @(negedge clk);
        chk("t5_ovr_pulse", 32'(overrun), 32'd0);
        tick(2);
        chk("t5_ovr_count", 32'(ov_cnt - ov0), 32'd0);
        pop_chk("t5_b2", 8'h20);
        pop_chk("t5_b3", 8'h30);
        pop_chk("t5_b4", 8'h40);
        pop_chk("t5_b5", 8'h55);
        @(negedge clk);
        chk("t5_empty", 32'(bif.rx_valid), 32'd0);
        tick(10);

        // Reset during data bit 4 of 0xF0
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rx  = 1'b0;
        tick(8 + 32);
        rx = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_valid", 32'(bif.rx_valid), 32'd0);
        chk("t6_data", 32'(bif.rx_data), 32'h00);
        tick(4 + 24 + 8 + 20);
        chk("t6_no_out", 32'(bif.rx_valid), 32'd0);
        chk("t6_pulses", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);
        send_frame(8'h7E, 1'b1);
        tick(1);
        pop_chk("t6_next", 8'h7E);
        @(negedge clk);
        chk("t6_empty", 32'(bif.rx_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
